// File: rtl/vend_dispatch_arbiter.sv
// Two-station coin credit tracker feeding a round-robin arbiter that
// time-shares one dispenser for a fixed hold window per vend.
module vend_dispatch_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] five,
  input  logic [1:0] ten,
  output logic       dispense,
  output logic       grant,
  output logic       change,
  output logic [1:0] served,
  output logic [1:0] coin_reject,
  output logic [1:0] pending
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_DISP   = 1'b1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  logic [0:0]    r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_served;

  logic [1:0] w_pending;
  logic [1:0] w_four;
  logic       w_done;
  logic       w_pick;

  assign w_done = (r_state == S_DISP) && (r_cnt == LAST_CNT);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_station
      logic [2:0] r_credit;
      logic       r_reject;
      logic [2:0] w_credit_next;
      logic       w_reject_next;
      logic       w_clear;

      assign w_clear        = w_done && (r_grant == 1'(gi));
      assign w_pending[gi]  = (r_credit >= 3'd3);
      assign w_four[gi]     = (r_credit == 3'd4);
      assign coin_reject[gi] = r_reject;

      // Simultaneous five+ten keeps the five and refuses the ten.
      always_comb begin
        w_credit_next = r_credit;
        w_reject_next = 1'b0;
        if (five[gi] || ten[gi]) begin
          if (r_credit <= 3'd2) begin
            w_credit_next = five[gi] ? (r_credit + 3'd1) : (r_credit + 3'd2);
            w_reject_next = five[gi] && ten[gi];
          end else begin
            w_reject_next = 1'b1;
          end
        end
        if (w_clear) begin
          w_credit_next = 3'd0;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_credit <= 3'd0;
          r_reject <= 1'b0;
        end else begin
          r_credit <= w_credit_next;
          r_reject <= w_reject_next;
        end
      end
    end
  endgenerate

  // Tie goes to the station that was not served last.
  always_comb begin
    w_pick = ~r_last_grant;
    case (w_pending)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      default: w_pick = ~r_last_grant;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_served     <= 2'b00;
    end else begin
      r_served <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|w_pending) begin
            r_state <= S_DISP;
            r_grant <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_DISP: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_done) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_grant;
            r_served     <= r_grant ? 2'b10 : 2'b01;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dispense = (r_state == S_DISP);
  assign grant    = r_grant;
  assign change   = dispense && w_four[r_grant];
  assign served   = r_served;
  assign pending  = w_pending;

endmodule

// File: tb/tb_vend_dispatch_arbiter.sv
// Scenario bench for vend_dispatch_arbiter: per-cycle stimulus and expected
// output vectors are queued together, then replayed and compared cycle by cycle.
module tb_vend_dispatch_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] five;
  logic [1:0] ten;
  logic       dispense;
  logic       grant;
  logic       change;
  logic [1:0] served;
  logic [1:0] coin_reject;
  logic [1:0] pending;

  int errors = 0;
  int checks = 0;

  // stim = {reset_n, five[1:0], ten[1:0]}
  logic [4:0] stim_q[$];
  // exp  = {dispense, grant, change, served[1:0], coin_reject[1:0], pending[1:0]}
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  vend_dispatch_arbiter #(.HOLD_CYCLES(HOLD), .CW(8)) dut (
    .clk(clk),
    .reset(reset),
    .five(five),
    .ten(ten),
    .dispense(dispense),
    .grant(grant),
    .change(change),
    .served(served),
    .coin_reject(coin_reject),
    .pending(pending)
  );

  wire [8:0] obs = {dispense, grant, change, served, coin_reject, pending};

  always @(negedge clk) begin
    if (reset && served != 2'b00)
      $display("vend complete: served=%b at %0t", served, $time);
  end

  function automatic logic [8:0] ev(input logic d, input logic g, input logic c,
                                    input logic [1:0] s, input logic [1:0] r,
                                    input logic [1:0] p);
    return {d, g, c, s, r, p};
  endfunction

  function automatic void add(input logic rn, input logic [1:0] f, input logic [1:0] t,
                              input logic [8:0] e);
    stim_q.push_back({rn, f, t});
    exp_q.push_back(e);
  endfunction

  // Idle-input dispense cycles with constant grant/change/pending.
  function automatic void add_disp(input logic g, input logic c, input logic [1:0] p,
                                   input int n);
    for (int k = 0; k < n; k++) add(1'b1, 2'b00, 2'b00, ev(1'b1, g, c, 2'b00, 2'b00, p));
  endfunction

  task automatic drive(input logic [4:0] s);
    {reset, five, ten} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    add(1'b0, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1'b0, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1'b1, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset cyc%0d: observed %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_basic();
    logic [8:0] e;
    add(1, 2'b01, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b01, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b01, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b01));
    add_disp(1'b0, 1'b0, 2'b01, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b01, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL basic cyc%0d: observed %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_change();
    logic [8:0] e;
    add(1, 2'b00, 2'b10, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b00, 2'b10, ev(0, 0, 0, 2'b00, 2'b00, 2'b10));
    add_disp(1'b1, 1'b1, 2'b10, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b10, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL change cyc%0d: observed %b required %b", k, obs, e);
      end
    end
  endtask

  // Both stations complete on the same edge, twice; last_grant is 1 each time.
  task automatic test_back_to_back();
    logic [8:0] e;
    add(1, 2'b11, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b11, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b11, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b11));
    add_disp(1'b0, 1'b0, 2'b11, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b01, 2'b00, 2'b10));
    add_disp(1'b1, 1'b0, 2'b10, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b10, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b00, 2'b11, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b11, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b11));
    add_disp(1'b0, 1'b0, 2'b11, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b01, 2'b00, 2'b10));
    add_disp(1'b1, 1'b0, 2'b10, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b10, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: observed %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_reject_own();
    logic [8:0] e;
    add(1, 2'b00, 2'b01, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b01, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b01));
    add(1, 2'b00, 2'b00, ev(1, 0, 0, 2'b00, 2'b00, 2'b01));
    add(1, 2'b01, 2'b00, ev(1, 0, 0, 2'b00, 2'b01, 2'b01));
    add(1, 2'b00, 2'b00, ev(1, 0, 0, 2'b00, 2'b00, 2'b01));
    add(1, 2'b00, 2'b00, ev(1, 0, 0, 2'b00, 2'b00, 2'b01));
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b01, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reject_own cyc%0d: observed %b required %b", k, obs, e);
      end
    end
  endtask

  // five+ten together leaves credit 1, so two more fives are needed to vend.
  task automatic test_both_coins();
    logic [8:0] e;
    add(1, 2'b10, 2'b10, ev(0, 0, 0, 2'b00, 2'b10, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b10, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b10, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b10));
    add_disp(1'b1, 1'b0, 2'b10, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b10, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL both_coins cyc%0d: observed %b required %b", k, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    add(1, 2'b00, 2'b01, ev(0, 1, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b01, 2'b00, ev(0, 1, 0, 2'b00, 2'b00, 2'b01));
    add(1, 2'b00, 2'b00, ev(1, 0, 0, 2'b00, 2'b00, 2'b01));
    add(1, 2'b00, 2'b00, ev(1, 0, 0, 2'b00, 2'b00, 2'b01));
    add(0, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b01, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b01, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    add(1, 2'b01, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b01));
    add_disp(1'b0, 1'b0, 2'b01, HOLD);
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b01, 2'b00, 2'b00));
    add(1, 2'b00, 2'b00, ev(0, 0, 0, 2'b00, 2'b00, 2'b00));
    for (int k = 0; exp_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: observed %b required %b", k, obs, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    five  = 2'b00;
    ten   = 2'b00;
    test_reset();
    test_basic();
    test_change();
    test_back_to_back();
    test_reject_own();
    test_both_coins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
